// File: rtl/rx_fsrc_pkg.sv
// Shared types and helpers for the RX FSRC sequencer.
package rx_fsrc_pkg;

  // Sequencer states; encodings are visible through the status register.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } fsrc_ctrl_state_t;

  // Bits needed to hold the number of set flags in an n-bit hole mask.
  function automatic int pop_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rx_fsrc_popcount.sv
// Counts the invalid-sample flags of one beat (purely combinational).
module rx_fsrc_popcount
  import rx_fsrc_pkg::*;
#(
  parameter int NUM_SAMPLES = 32,
  localparam int PW = pop_width(NUM_SAMPLES)
) (
  input  logic [NUM_SAMPLES-1:0] holes,
  output logic [PW-1:0]          count
);

  // Sum the individual hole flags into a zero-extended count.
  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_SAMPLES; i++) begin
      count = count + PW'(holes[i]);
    end
  end

endmodule

// File: rtl/rx_fsrc_ctrl.sv
// Sequencer for the RX FSRC invalid-sample removal stage: gates fsrc_en
// so mode changes only happen on an aligned start or across an idle gap,
// and keeps saturating hole/beat statistics for the register map.
module rx_fsrc_ctrl
  import rx_fsrc_pkg::*;
#(
  parameter int NP            = 16,
  parameter int NUM_SAMPLES   = 32,
  parameter int DRAIN_IDLE    = 4,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_enable,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [NUM_SAMPLES-1:0] in_holes,
  input  logic                   clear_counts,
  output logic                   fsrc_en,
  output logic [1:0]             state,
  output logic [CNT_WIDTH-1:0]   removed_count,
  output logic [CNT_WIDTH-1:0]   beat_count,
  output logic                   drain_timeout
);

  localparam int PW = pop_width(NUM_SAMPLES);
  localparam int IW = $clog2(DRAIN_IDLE + 1);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Reject parameter sets that would make the drain logic meaningless.
  if (NP < 1 || DRAIN_IDLE < 1 || DRAIN_TIMEOUT <= DRAIN_IDLE) begin : g_bad_params
    $error("rx_fsrc_ctrl: invalid NP/DRAIN_IDLE/DRAIN_TIMEOUT combination");
  end

  fsrc_ctrl_state_t state_q, state_d;
  logic [IW-1:0]    idle_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic [PW-1:0]    hole_count;
  logic [SW-1:0]    removed_sum;
  logic             idle_hit, tmo_hit, timeout_exit, count_beat;

  rx_fsrc_popcount #(.NUM_SAMPLES(NUM_SAMPLES)) u_popcount (
    .holes (in_holes),
    .count (hole_count)
  );

  // Drain exits fire on the cycle whose update would reach the limit, so
  // fsrc_en drops exactly DRAIN_IDLE cycles after entry on a quiet stream.
  // A graceful idle exit wins over a coincident timeout.
  assign idle_hit     = (state_q == ST_DRAIN) && !in_valid && (idle_cnt == IW'(DRAIN_IDLE - 1));
  assign tmo_hit      = (state_q == ST_DRAIN) && (tmo_cnt == TW'(DRAIN_TIMEOUT - 1));
  assign timeout_exit = tmo_hit && !idle_hit;
  assign count_beat   = (state_q == ST_ACTIVE) && in_valid;
  assign removed_sum  = SW'(removed_count) + SW'(hole_count);
  assign state        = state_q;

  // Next-state decision for the enable sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cfg_enable) state_d = ST_ARMED;
      ST_ARMED:  if (!cfg_enable) state_d = ST_IDLE;
                 else if (start) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!cfg_enable) state_d = ST_DRAIN;
      ST_DRAIN:  if (idle_hit || tmo_hit) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register and the enable, registered from the next state so both agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fsrc_en <= 1'b0;
    end else begin
      state_q <= state_d;
      fsrc_en <= (state_d == ST_ACTIVE) || (state_d == ST_DRAIN);
    end
  end

  // Idle-run and timeout counters, held at zero outside DRAIN so each entry starts fresh.
  always_ff @(posedge clk) begin
    if (reset || state_q != ST_DRAIN) begin
      idle_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      tmo_cnt  <= tmo_cnt + TW'(1);
      idle_cnt <= in_valid ? '0 : idle_cnt + IW'(1);
    end
  end

  // Saturating statistics and sticky timeout flag; a clear beats any update.
  always_ff @(posedge clk) begin
    if (reset || clear_counts) begin
      beat_count    <= '0;
      removed_count <= '0;
      drain_timeout <= 1'b0;
    end else begin
      if (count_beat) begin
        if (beat_count != CNT_MAX) beat_count <= beat_count + CNT_WIDTH'(1);
        removed_count <= (removed_sum > SW'(CNT_MAX)) ? CNT_MAX : removed_sum[CNT_WIDTH-1:0];
      end
      if (timeout_exit) drain_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_fsrc_ctrl.sv
// Bench for rx_fsrc_ctrl: two instances share stimulus, one with default
// limits and one with a short timeout and 4-bit counters.
module tb_rx_fsrc_ctrl;

  localparam int DRAIN_IDLE = 4;
  localparam int TMO_A      = 1024;
  localparam int TMO_T      = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_enable = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_holes = '0;
  logic        clear_counts = 1'b0;

  logic        fsrc_en_a, fsrc_en_t, drain_timeout_a, drain_timeout_t;
  logic [1:0]  state_a, state_t;
  logic [31:0] removed_a, beat_a;
  logic [3:0]  removed_t, beat_t;

  int checks = 0;
  int errors = 0;

  // Reference model: mode number, idle run length, drain age, counts.
  int     m_state[2];
  int     m_run[2];
  int     m_dcyc[2];
  longint m_beats[2];
  longint m_removed[2];
  bit     m_flag[2];

  rx_fsrc_ctrl #(.NP(16), .NUM_SAMPLES(32), .DRAIN_IDLE(DRAIN_IDLE),
                 .DRAIN_TIMEOUT(TMO_A), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .start(start),
    .in_valid(in_valid), .in_holes(in_holes), .clear_counts(clear_counts),
    .fsrc_en(fsrc_en_a), .state(state_a), .removed_count(removed_a),
    .beat_count(beat_a), .drain_timeout(drain_timeout_a)
  );

  rx_fsrc_ctrl #(.NP(16), .NUM_SAMPLES(32), .DRAIN_IDLE(DRAIN_IDLE),
                 .DRAIN_TIMEOUT(TMO_T), .CNT_WIDTH(4)) dut_t (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .start(start),
    .in_valid(in_valid), .in_holes(in_holes), .clear_counts(clear_counts),
    .fsrc_en(fsrc_en_t), .state(state_t), .removed_count(removed_t),
    .beat_count(beat_t), .drain_timeout(drain_timeout_t)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int     nxt, run, dcyc, tmo;
      bit     set_flag;
      longint cmax;
      cmax = (k == 0) ? 64'hFFFF_FFFF : 64'd15;
      tmo  = (k == 0) ? TMO_A : TMO_T;
      nxt = m_state[k]; run = 0; dcyc = 0; set_flag = 0;
      if (reset) begin
        m_state[k] = 0; m_run[k] = 0; m_dcyc[k] = 0;
        m_beats[k] = 0; m_removed[k] = 0; m_flag[k] = 0;
      end else begin
        case (m_state[k])
          0: if (cfg_enable) nxt = 1;
          1: if (!cfg_enable) nxt = 0; else if (start) nxt = 2;
          2: if (!cfg_enable) nxt = 3;
          default: begin
            run  = in_valid ? 0 : m_run[k] + 1;
            dcyc = m_dcyc[k] + 1;
            if (run >= DRAIN_IDLE) nxt = 0;
            else if (dcyc >= tmo) begin nxt = 0; set_flag = 1; end
          end
        endcase
        if (clear_counts) begin
          m_beats[k] = 0; m_removed[k] = 0; m_flag[k] = 0;
        end else begin
          if (m_state[k] == 2 && in_valid) begin
            m_beats[k]   = (m_beats[k] + 1 > cmax) ? cmax : m_beats[k] + 1;
            m_removed[k] = (m_removed[k] + $countones(in_holes) > cmax) ? cmax
                           : m_removed[k] + $countones(in_holes);
          end
          if (set_flag) m_flag[k] = 1;
        end
        m_run[k] = run; m_dcyc[k] = dcyc; m_state[k] = nxt;
      end
    end
  endtask

  task automatic check_all();
    checkOutput("a_state",   {30'd0, state_a}, m_state[0]);
    checkOutput("a_fsrc_en", {31'd0, fsrc_en_a}, {31'd0, (m_state[0] >= 2)});
    checkOutput("a_beats",   beat_a, m_beats[0][31:0]);
    checkOutput("a_removed", removed_a, m_removed[0][31:0]);
    checkOutput("a_tmo",     {31'd0, drain_timeout_a}, {31'd0, m_flag[0]});
    checkOutput("t_state",   {30'd0, state_t}, m_state[1]);
    checkOutput("t_fsrc_en", {31'd0, fsrc_en_t}, {31'd0, (m_state[1] >= 2)});
    checkOutput("t_beats",   {28'd0, beat_t}, m_beats[1][31:0]);
    checkOutput("t_removed", {28'd0, removed_t}, m_removed[1][31:0]);
    checkOutput("t_tmo",     {31'd0, drain_timeout_t}, {31'd0, m_flag[1]});
  endtask

  task automatic applyStimulus(input logic r, input logic cfg, input logic st, input logic v,
                               input logic [31:0] h, input logic clr);
    reset = r; cfg_enable = cfg; start = st; in_valid = v; in_holes = h; clear_counts = clr;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic cfg_r;
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_run[k] = 0; m_dcyc[k] = 0;
      m_beats[k] = 0; m_removed[k] = 0; m_flag[k] = 0;
    end

    // Reset
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rst_state", {30'd0, state_a}, 0);
    checkOutput("rst_en", {31'd0, fsrc_en_a}, 0);

    // Arm, then start on cycle 10
    for (int i = 1; i < 10; i++) applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("plan_armed", {30'd0, state_a}, 1);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("plan_active", {30'd0, state_a}, 2);
    checkOutput("plan_en_up", {31'd0, fsrc_en_a}, 1);

    // Five counted beats, two non-valid beats
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 1, 32'h0000_0003, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 0, 32'hFFFF_FFFF, 0);
    checkOutput("plan_beats", beat_a, 5);
    checkOutput("plan_removed", removed_a, 10);

    // Drain with toggling valid, then quiet
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, (i % 2 == 0), 32'h0000_FFFF, 0);
    checkOutput("plan_drain_hold", {31'd0, fsrc_en_a}, 1);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("plan_drain_done", {30'd0, state_a}, 0);
    checkOutput("plan_no_tmo", {31'd0, drain_timeout_a}, 0);

    // Forced timeout on the short-timeout instance
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("tmo_state", {30'd0, state_t}, 0);
    checkOutput("tmo_flag", {31'd0, drain_timeout_t}, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("tmo_sticky", {31'd0, drain_timeout_t}, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("tmo_cleared", {31'd0, drain_timeout_t}, 0);

    // Start and disable together in ARMED
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("sim_idle", {30'd0, state_a}, 0);
    checkOutput("sim_no_en", {31'd0, fsrc_en_a}, 0);

    // Clear on a counting beat
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 32'h0000_0003, 0);
    applyStimulus(0, 1, 0, 1, 32'h0000_000F, 1);
    checkOutput("clr_beats", beat_a, 0);
    checkOutput("clr_removed", removed_a, 0);

    // Saturation
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 1, 32'hFFFF_FFFF, 0);
    checkOutput("sat_beats_t", {28'd0, beat_t}, 15);
    checkOutput("sat_removed_t", {28'd0, removed_t}, 15);
    checkOutput("sat_beats_a", beat_a, 20);
    checkOutput("sat_removed_a", removed_a, 640);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    // Randomized traffic
    cfg_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) cfg_r = ~cfg_r;
      applyStimulus($urandom_range(0, 249) == 0, cfg_r, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 2) != 0, $urandom & $urandom & $urandom,
                    $urandom_range(0, 99) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_fsrc_ctrl.md
# rx_fsrc_ctrl

Sequencer for the RX FSRC invalid-sample removal path. Drives the removal stage's `fsrc_en` so the stage enters FSRC mode only on an aligned start trigger and leaves it only across an idle gap in the input stream, so no partially packed output beat is dropped or corrupted. Also keeps saturating statistics on removed samples and active beats for the register map. Sits beside the removal stage in the RX FSRC chain and takes its configuration from the AXI register bank.

## Interface
- `NP`, 16, sample width in bits
- `NUM_SAMPLES`, 32, samples per beat; width of `in_holes`
- `DRAIN_IDLE`, 4, consecutive `in_valid`-low cycles required to leave DRAIN; at least the removal pipeline depth
- `DRAIN_TIMEOUT`, 1024, maximum cycles in DRAIN before a forced exit
- `CNT_WIDTH`, 32, width of the statistics counters

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high
- `cfg_enable`  in  1  level; software request for FSRC mode
- `start`  in  1  one-cycle aligned trigger
- `in_valid`  in  1  upstream beat valid, the same signal that feeds the removal stage
- `in_holes`  in  NUM_SAMPLES  per-sample invalid flags for the current beat, qualified by `in_valid`
- `clear_counts`  in  1  one-cycle pulse; clears the statistics counters
- `fsrc_en`  out  1  registered enable to the removal stage
- `state`  out  2  current state encoding, for status readback
- `removed_count`  out  CNT_WIDTH  saturating count of invalid samples seen while ACTIVE
- `beat_count`  out  CNT_WIDTH  saturating count of valid beats seen while ACTIVE
- `drain_timeout`  out  1  sticky; set on a forced DRAIN exit

## Operation
- State machine, encoded IDLE=0, ARMED=1, ACTIVE=2, DRAIN=3:
  - IDLE: go to ARMED when `cfg_enable`=1. `start` is ignored.
  - ARMED: go to IDLE when `cfg_enable`=0. Otherwise go to ACTIVE on `start`=1. If `cfg_enable` drops in the same cycle as `start`, go to IDLE.
  - ACTIVE: go to DRAIN when `cfg_enable`=0. `start` is ignored.
  - DRAIN: go to IDLE when the idle counter reaches `DRAIN_IDLE`, or when the timeout counter reaches `DRAIN_TIMEOUT`; a timeout exit sets `drain_timeout`. Reasserting `cfg_enable` during DRAIN does not abort it: the FSM finishes DRAIN, enters IDLE, then goes to ARMED on the next cycle.
- Enable output: `fsrc_en`=1 in ACTIVE and DRAIN, 0 otherwise. It is a registered output, derived from the next-state value so that it coincides with `state`.
- Idle counter: reset to 0 on entering DRAIN. Increments on each DRAIN cycle with `in_valid`=0. Returns to 0 on any `in_valid`=1.
- Timeout counter: reset to 0 on entering DRAIN. Increments on every DRAIN cycle.
- Statistics, updated only in ACTIVE on an `in_valid`=1 beat:
  - `beat_count` += 1
  - `removed_count` += popcount(`in_holes`); the popcount is $clog2(NUM_SAMPLES+1) bits, zero-extended.
  - Both counters saturate at all-ones and do not wrap.
  - Beats that arrive in DRAIN are not counted.
- `clear_counts` clears both counters and `drain_timeout`. It takes priority over an increment or a timeout set in the same cycle.

## Timing
- Reset values: state IDLE, `fsrc_en`=0, `state`=0, both counters 0, `drain_timeout`=0. Internal counters are 0.
- Reset asserted in any state forces IDLE on the next edge; `fsrc_en` falls in that same cycle.
- Enable latency:
  - `start` sampled at edge N in ARMED gives `state`=ACTIVE and `fsrc_en`=1 after edge N.
  - `cfg_enable`=0 sampled in ACTIVE at edge N gives `state`=DRAIN after edge N; `fsrc_en` stays 1.
- DRAIN exit: with `in_valid` held 0 throughout DRAIN, `fsrc_en` falls exactly `DRAIN_IDLE` cycles after DRAIN is entered.
- Counter latency: `in_valid` and `in_holes` sampled at edge N are reflected in the counters after edge N (1 cycle).
- No backpressure: the block only observes the stream and never stalls it.

## Structure
- Package `rx_fsrc_pkg`: `fsrc_ctrl_state_t` enum (2-bit, encodings as above), plus the popcount-width function.
- Sub-module `rx_fsrc_popcount` (parameter `NUM_SAMPLES`): combinational adder tree, optionally with one pipeline register. If the register is used, the `in_valid`/ACTIVE qualifier must be delayed by the same stage, and the 1-cycle counter latency above becomes 2.
- Counters and FSM live in `rx_fsrc_ctrl`.

## Test plan
- Reset then `cfg_enable`=1, `start` at cycle 10 -> `state` 0→1 after one cycle, →2 after cycle 10; `fsrc_en`=1 from cycle 11.
- ACTIVE: 5 valid beats each with `in_holes`=32'h0000_0003, plus 2 beats with `in_valid`=0 and `in_holes`=all-ones -> `beat_count`=5, `removed_count`=10.
- Drop `cfg_enable` with `in_valid` toggling every cycle for 20 cycles, then held low -> `fsrc_en` stays 1 until 4 idle cycles after `in_valid` last fell; `drain_timeout`=0.
- `DRAIN_TIMEOUT`=16 with `in_valid` constantly 1 in DRAIN -> IDLE after 16 cycles; `drain_timeout`=1 until a `clear_counts` pulse.
- Simultaneous events:
  - `start` and `cfg_enable`=0 in the same ARMED cycle -> IDLE; `fsrc_en` never rises.
  - `clear_counts` on a counting beat -> both counters 0.
- Saturation: `CNT_WIDTH`=4, 20 beats with all holes set -> `beat_count`=15 and `removed_count`=15, held at those values.
